// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with credit-limited imem requests and a response FIFO to decode.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pcplus4,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_flush_cnt
);
    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0] cnt_t;
    localparam cnt_t W_DEPTH = cnt_t'(DEPTH);
    typedef enum logic {BOOT, FETCH} state_t;

    state_t        r_state, w_state_nxt;
    logic [31:0]   r_pc, w_pc_nxt;
    cnt_t          r_out, r_disc, r_cnt, w_out_nxt, w_disc_nxt, w_cnt_nxt;
    logic [AW-1:0] r_rd, r_wr, r_qrd, r_qwr;
    logic [31:0]   r_instr [DEPTH];
    logic [31:0]   r_ipc [DEPTH];
    logic [31:0]   r_qpc [DEPTH];
    logic          w_acc, w_drop, w_push, w_pop, w_valid;

    always_comb begin
        w_state_nxt    = FETCH;
        w_valid        = r_cnt != '0;
        imem_req_valid = (r_state == FETCH) && (r_out + r_cnt < W_DEPTH) && !redirect_valid;
        w_acc          = imem_req_valid && imem_req_ready;
        w_drop         = imem_rsp_valid && r_disc != '0;
        w_push         = imem_rsp_valid && r_disc == '0 && !redirect_valid;
        w_pop          = w_valid && if_ready && !redirect_valid;
        w_out_nxt      = r_out + cnt_t'(w_acc) - cnt_t'(imem_rsp_valid);
        // everything still in flight after a redirect belongs to the wrong path
        w_disc_nxt     = redirect_valid ? w_out_nxt : r_disc - cnt_t'(w_drop);
        w_cnt_nxt      = redirect_valid ? '0 : r_cnt + cnt_t'(w_push) - cnt_t'(w_pop);
        w_pc_nxt       = redirect_valid ? {redirect_pc[31:2], 2'b00} : w_acc ? r_pc + 32'd4 : r_pc;
    end

    assign imem_addr  = r_pc;
    assign if_valid   = w_valid;
    assign if_instr   = w_valid ? r_instr[r_rd] : '0;
    assign if_pc      = w_valid ? r_ipc[r_rd] : '0;
    assign if_pcplus4 = w_valid ? r_ipc[r_rd] + 32'd4 : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= BOOT;
            r_pc    <= RESET_PC;
            r_out   <= '0;
            r_disc  <= '0;
            r_cnt   <= '0;
            r_rd    <= '0;
            r_wr    <= '0;
            r_qrd   <= '0;
            r_qwr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_out   <= w_out_nxt;
            r_disc  <= w_disc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rd    <= redirect_valid ? '0 : r_rd + AW'(w_pop);
            r_wr    <= redirect_valid ? '0 : r_wr + AW'(w_push);
            r_qrd   <= r_qrd + AW'(imem_rsp_valid);
            r_qwr   <= r_qwr + AW'(w_acc);
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc)
            r_qpc[r_qwr] <= r_pc;
        if (w_push) begin
            r_instr[r_wr] <= imem_rsp_data;
            r_ipc[r_wr]   <= r_qpc[r_qrd];
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && imem_rsp_valid)
            assert (r_out != '0);
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_fetch_cnt, r_flush_cnt;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_fetch_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_fetch_cnt <= r_fetch_cnt + 32'(w_pop);
            r_flush_cnt <= r_flush_cnt + (redirect_valid ? 32'(r_cnt) + 32'(imem_rsp_valid) : 32'(w_drop));
        end
    end
    assign perf_fetch_cnt = r_fetch_cnt;
    assign perf_flush_cnt = r_flush_cnt;
`else
    assign perf_fetch_cnt = '0;
    assign perf_flush_cnt = '0;
`endif
endmodule
